// File: rtl/audio_feeder_pkg.sv
// ---------------------------------------------------------------------------
// audio_feeder_pkg
//
// Shared constants and helpers for the audio interpolating feeder.
//   - default sample width, FIFO depth and ramp length
//   - width helpers for the ramp accumulator and the per-tick step
//   - midscale constant and signed-to-offset-binary conversion
//
// The helpers work on a wide 64-bit word so that any sample width below
// 64 bits can use them; callers cast the result back to their own width.
// ---------------------------------------------------------------------------
package audio_feeder_pkg;

    localparam int SIGNALWIDTH_DEFAULT = 16;
    localparam int FIFO_LOG2_DEFAULT   = 2;
    localparam int RATE_LOG2_DEFAULT   = 10;
    localparam int MAX_WIDTH           = 64;

    // Accumulator holds integer part, RATE_LOG2 fraction bits and one guard
    // bit so a full-scale ramp never overflows.
    function automatic int acc_width(input int sample_width, input int rate_log2);
        return sample_width + rate_log2 + 1;
    endfunction

    // Difference of two signed samples needs exactly one extra bit.
    function automatic int step_width(input int sample_width);
        return sample_width + 1;
    endfunction

    // A one followed by sample_width-1 zeros: signed zero in offset binary.
    function automatic logic [MAX_WIDTH-1:0] midscale(input int sample_width);
        return MAX_WIDTH'(1) << (sample_width - 1);
    endfunction

    // Two's complement to offset binary is just an inversion of the MSB.
    function automatic logic [MAX_WIDTH-1:0] to_offset(input logic [MAX_WIDTH-1:0] sample,
                                                       input int sample_width);
        return sample ^ midscale(sample_width);
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo
//
// Small synchronous FIFO holding packed stereo frames {left, right}.
// Reads are first-word fall-through: pop_data always shows the oldest entry.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (empties the FIFO)
//   push_valid     write request; accepted only while not full
//   push_data      frame to store
//   pop            read strobe; ignored while empty
//   pop_data       oldest stored frame
//   level          registered occupancy, 0 .. 2**DEPTH_LOG2
//   full, empty    decoded from the registered level
// ---------------------------------------------------------------------------
module audio_sample_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int LEVEL_W = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] DEPTH = LEVEL_W'(1) << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_fire;
    logic                  pop_fire;

    // Full/empty come from the registered level only, so a pop in this
    // cycle can never make the FIFO look writable in the same cycle.
    assign full      = (level == DEPTH);
    assign empty     = (level == '0);
    assign push_fire = push_valid && !full;
    assign pop_fire  = pop && !empty;
    assign pop_data  = mem[rd_ptr];

    // Storage array; contents need no reset because the pointers and the
    // level define what is valid.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the
    // level unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_interp_feeder.sv
// ---------------------------------------------------------------------------
// audio_interp_feeder
//
// Buffers signed stereo PCM frames from the mixer, takes one frame per output
// period and linearly ramps each channel from the old to the new value, then
// presents the result to the DAC as unsigned offset-binary words.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   in_valid       source frame valid
//   in_ready       FIFO can take a frame this cycle
//   in_l, in_r     two's complement samples
//   mute           force the ramp target to signed zero
//   d_l, d_r       offset-binary DAC words (midscale in reset)
//   underrun       one-cycle pulse when a period tick finds the FIFO empty
//   fifo_level     registered FIFO occupancy
// ---------------------------------------------------------------------------
module audio_interp_feeder
    import audio_feeder_pkg::*;
#(
    parameter int SIGNALWIDTH = SIGNALWIDTH_DEFAULT,
    parameter int FIFO_LOG2   = FIFO_LOG2_DEFAULT,
    parameter int RATE_LOG2   = RATE_LOG2_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIGNALWIDTH-1:0] in_l,
    input  logic [SIGNALWIDTH-1:0] in_r,
    input  logic                   mute,
    output logic [SIGNALWIDTH-1:0] d_l,
    output logic [SIGNALWIDTH-1:0] d_r,
    output logic                   underrun,
    output logic [FIFO_LOG2:0]     fifo_level
);

    localparam int ACC_W  = acc_width(SIGNALWIDTH, RATE_LOG2);
    localparam int STEP_W = step_width(SIGNALWIDTH);
    localparam logic [SIGNALWIDTH-1:0] MIDSCALE = SIGNALWIDTH'(midscale(SIGNALWIDTH));

    logic [RATE_LOG2-1:0]     phase;
    logic                     tick;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic [2*SIGNALWIDTH-1:0] fifo_data;
    logic [SIGNALWIDTH-1:0]   frame_sample [2];
    logic [SIGNALWIDTH-1:0]   dac_word [2];

    assign tick     = &phase;
    assign fifo_pop = tick && !fifo_empty;
    assign in_ready = !fifo_full;

    assign frame_sample[0] = fifo_data[2*SIGNALWIDTH-1:SIGNALWIDTH];
    assign frame_sample[1] = fifo_data[SIGNALWIDTH-1:0];

    assign d_l = dac_word[0];
    assign d_r = dac_word[1];

    audio_sample_fifo #(
        .DATA_WIDTH (2*SIGNALWIDTH),
        .DEPTH_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (in_valid),
        .push_data  ({in_l, in_r}),
        .pop        (fifo_pop),
        .pop_data   (fifo_data),
        .level      (fifo_level),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Free-running period counter; the cycle at its maximum is the tick, so
    // the period is exactly 2**RATE_LOG2 cycles. Underrun is registered so
    // it appears as a clean one-cycle pulse after the starved tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            underrun <= 1'b0;
        end else begin
            phase    <= phase + RATE_LOG2'(1);
            underrun <= tick && fifo_empty;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic signed [SIGNALWIDTH-1:0] target_q;
        logic signed [SIGNALWIDTH-1:0] target_next;
        logic signed [STEP_W-1:0]      step_q;
        logic signed [STEP_W-1:0]      step_next;
        logic signed [ACC_W-1:0]       acc_q;
        logic [SIGNALWIDTH-1:0]        acc_int;
        logic [SIGNALWIDTH-1:0]        word_q;

        // Mute wins over a fresh frame; an empty FIFO simply repeats the
        // previous target so the output parks at its last value.
        always_comb begin
            target_next = target_q;
            if (mute) begin
                target_next = '0;
            end else if (!fifo_empty) begin
                target_next = frame_sample[ch];
            end
        end

        // One extra bit keeps the difference exact for a full-scale swing.
        assign step_next = {target_next[SIGNALWIDTH-1], target_next}
                         - {target_q[SIGNALWIDTH-1], target_q};

        // Dropping the fraction bits of a two's complement number floors it.
        assign acc_int = acc_q[RATE_LOG2 +: SIGNALWIDTH];

        // The accumulator adds the step on every edge. A step latched on a
        // tick is added over the following 2**RATE_LOG2 edges, the last of
        // which is the next tick, so the ramp always lands on the target
        // exactly with no drift and no divider.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                target_q <= '0;
                step_q   <= '0;
                acc_q    <= '0;
                word_q   <= MIDSCALE;
            end else begin
                acc_q  <= acc_q + {{RATE_LOG2{step_q[STEP_W-1]}}, step_q};
                word_q <= SIGNALWIDTH'(to_offset({{(MAX_WIDTH-SIGNALWIDTH){1'b0}}, acc_int},
                                                 SIGNALWIDTH));
                if (tick) begin
                    target_q <= target_next;
                    step_q   <= step_next;
                end
            end
        end

        assign dac_word[ch] = word_q;
    end

endmodule

// File: tb/tb_audio_interp_feeder.sv
// ---------------------------------------------------------------------------
// tb_audio_interp_feeder
//
// Self-checking bench for audio_interp_feeder with RATE_LOG2=4, FIFO_LOG2=2.
// A reference model tracks accepted frames in a scoreboard queue and
// predicts the DAC words, underrun pulses, level and ready every cycle;
// a vector table and a few directed sequences add endpoint checks.
// ---------------------------------------------------------------------------
module tb_audio_interp_feeder;

    localparam int SW     = 16;
    localparam int FL     = 2;
    localparam int RL     = 4;
    localparam int PERIOD = 16;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2 * PERIOD + 4;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          in_valid = 1'b0;
    logic          mute     = 1'b0;
    logic [SW-1:0] in_l     = '0;
    logic [SW-1:0] in_r     = '0;
    logic          in_ready;
    logic [SW-1:0] d_l;
    logic [SW-1:0] d_r;
    logic          underrun;
    logic [FL:0]   fifo_level;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    typedef struct packed {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
    } frame_t;

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic          m;
        logic [SW-1:0] exp_l;
        logic [SW-1:0] exp_r;
    } vec_t;

    vec_t table_v [6];

    // Reference model state
    frame_t        sb_q [$];
    int            m_phase = 0;
    int            m_k     = 0;
    longint        m_old_l = 0;
    longint        m_new_l = 0;
    longint        m_old_r = 0;
    longint        m_new_r = 0;
    logic [SW-1:0] m_d_l   = 16'h8000;
    logic [SW-1:0] m_d_r   = 16'h8000;
    logic          m_underrun = 1'b0;

    bit            t_tick;
    int            t_size;
    longint        t_l;
    longint        t_r;
    frame_t        t_f;

    always #5 clk = ~clk;

    audio_interp_feeder #(
        .SIGNALWIDTH (SW),
        .FIFO_LOG2   (FL),
        .RATE_LOG2   (RL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_l       (in_l),
        .in_r       (in_r),
        .mute       (mute),
        .d_l        (d_l),
        .d_r        (d_r),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    // Expected DAC word after k of 16 ramp additions from old to new.
    function automatic logic [SW-1:0] word_of(input longint old_t, input longint new_t, input int k);
        longint acc;
        longint ip;
        acc = old_t * PERIOD + longint'(k) * (new_t - old_t);
        ip  = acc >>> RL;
        return SW'(ip + 32768);
    endfunction

    task automatic checkOutput(input string name, input logic [SW-1:0] actual, input logic [SW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: advances on each clock edge using the pre-edge state,
    // the scoreboard queue standing in for the FIFO contents.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_q.delete();
            m_phase    = 0;
            m_k        = 0;
            m_old_l    = 0;
            m_new_l    = 0;
            m_old_r    = 0;
            m_new_r    = 0;
            m_d_l      = 16'h8000;
            m_d_r      = 16'h8000;
            m_underrun = 1'b0;
        end else begin
            t_tick     = (m_phase == PERIOD - 1);
            t_size     = sb_q.size();
            m_d_l      = word_of(m_old_l, m_new_l, m_k);
            m_d_r      = word_of(m_old_r, m_new_r, m_k);
            m_underrun = t_tick && (t_size == 0);
            if (t_tick) begin
                t_l = m_new_l;
                t_r = m_new_r;
                if (t_size > 0) begin
                    t_f = sb_q.pop_front();
                    t_l = longint'($signed(t_f.l));
                    t_r = longint'($signed(t_f.r));
                end
                if (mute) begin
                    t_l = 0;
                    t_r = 0;
                end
                m_old_l = m_new_l;
                m_new_l = t_l;
                m_old_r = m_new_r;
                m_new_r = t_r;
                m_k     = 0;
            end else begin
                m_k = m_k + 1;
            end
            if (in_valid && t_size < DEPTH) begin
                t_f.l = in_l;
                t_f.r = in_r;
                sb_q.push_back(t_f);
            end
            m_phase = (m_phase + 1) % PERIOD;
        end
    end

    // Every cycle, compare all outputs against the model away from the edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("d_l", d_l, m_d_l);
            checkOutput("d_r", d_r, m_d_r);
            checkOutput("underrun", {15'b0, underrun}, {15'b0, m_underrun});
            checkOutput("fifo_level", {13'b0, fifo_level}, SW'(sb_q.size()));
            checkOutput("in_ready", {15'b0, in_ready}, {15'b0, (sb_q.size() < DEPTH)});
        end
    end

    // Present one frame at a falling edge and hold it until accepted.
    task automatic applyStimulus(input logic [SW-1:0] l, input logic [SW-1:0] r);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_l     = l;
        in_r     = r;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("push_ready", {15'b0, in_ready}, 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitPhase(input int p);
        int guard;
        guard = 0;
        while (m_phase != p && guard < 2 * PERIOD) begin
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        int drops;
        int n;
        logic [SW-1:0] prev;

        table_v[0] = '{16'h4000, 16'hC000, 1'b0, 16'hC000, 16'h4000};
        table_v[1] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0000, 16'hFFFF};
        table_v[2] = '{16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 16'h0000};
        table_v[3] = '{16'h0001, 16'hFFFF, 1'b0, 16'h8001, 16'h7FFF};
        table_v[4] = '{16'h1234, 16'hEDCC, 1'b1, 16'h8000, 16'h8000};
        table_v[5] = '{16'hFFFF, 16'h0000, 1'b0, 16'h7FFF, 16'h8000};

        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        check_en = 1'b1;
        $display("[TB] reset released");
        checkOutput("reset_d_l", d_l, 16'h8000);
        checkOutput("reset_d_r", d_r, 16'h8000);
        checkOutput("reset_level", {13'b0, fifo_level}, 16'd0);
        checkOutput("reset_ready", {15'b0, in_ready}, 16'd1);

        // Idle: one underrun per period, outputs parked at midscale
        pulses = 0;
        repeat (3 * PERIOD) begin
            @(negedge clk);
            if (underrun) pulses++;
        end
        checkOutput("idle_underrun_count", SW'(pulses), 16'd3);
        checkOutput("idle_d_l", d_l, 16'h8000);

        // Vector table: single frame, settle, check landing values
        for (int i = 0; i < 6; i++) begin
            mute = table_v[i].m;
            applyStimulus(table_v[i].l, table_v[i].r);
            repeat (SETTLE) @(negedge clk);
            checkOutput($sformatf("vec%0d_d_l", i), d_l, table_v[i].exp_l);
            checkOutput($sformatf("vec%0d_d_r", i), d_r, table_v[i].exp_r);
            mute = 1'b0;
        end

        // Full swing bottom to top: must rise monotonically
        applyStimulus(16'h8000, 16'h8000);
        repeat (SETTLE) @(negedge clk);
        checkOutput("swing_bottom", d_l, 16'h0000);
        applyStimulus(16'h7FFF, 16'h7FFF);
        prev  = d_l;
        drops = 0;
        repeat (SETTLE) begin
            @(negedge clk);
            if (d_l < prev) drops++;
            prev = d_l;
        end
        checkOutput("swing_monotonic", SW'(drops), 16'd0);
        checkOutput("swing_top", d_l, 16'hFFFF);

        // Five frames back to back: fifth is held until a tick frees a slot
        waitPhase(0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(SW'(i * 16'h1000), SW'(-(i * 16'h1000)));
        end
        checkOutput("burst_level_full", {13'b0, fifo_level}, 16'd4);
        checkOutput("burst_ready_low", {15'b0, in_ready}, 16'd0);
        applyStimulus(16'h5000, 16'hB000);
        repeat (6 * PERIOD) @(negedge clk);
        checkOutput("burst_drained", {13'b0, fifo_level}, 16'd0);
        checkOutput("burst_last_l", d_l, 16'hD000);

        // Mute discards the popped frame, the next one survives
        waitPhase(2);
        applyStimulus(16'h7FFF, 16'h7FFF);
        applyStimulus(16'h2000, 16'h2000);
        mute = 1'b1;
        waitPhase(0);
        checkOutput("mute_discard_level", {13'b0, fifo_level}, 16'd1);
        waitPhase(8);
        mute = 1'b0;
        waitPhase(0);
        repeat (PERIOD + 2) @(negedge clk);
        checkOutput("mute_resume_l", d_l, 16'hA000);
        checkOutput("mute_resume_r", d_r, 16'hA000);

        // Reset in the middle of a ramp with frames queued
        waitPhase(2);
        applyStimulus(16'h6000, 16'h6000);
        waitPhase(2);
        applyStimulus(16'h1111, 16'h1111);
        applyStimulus(16'h2222, 16'h2222);
        applyStimulus(16'h3333, 16'h3333);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_d_l", d_l, 16'h8000);
        checkOutput("async_reset_d_r", d_r, 16'h8000);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_level", {13'b0, fifo_level}, 16'd0);
        checkOutput("post_reset_ready", {15'b0, in_ready}, 16'd1);
        n = 0;
        while (underrun !== 1'b1 && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        checkOutput("post_reset_underrun", {15'b0, underrun}, 16'd1);

        repeat (4) @(negedge clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_interp_feeder.md
Name: audio_interp_feeder

Overview:
Stereo sample feeder that sits directly upstream of the hybrid PWM/sigma-delta DAC stage. It accepts signed PCM frames from the core audio mixer through a valid/ready handshake and buffers them in a small FIFO. It dequeues one frame per fixed output period and linearly ramps each channel from the previous frame to the new one. It then converts the result to the unsigned offset-binary words (d_l/d_r) that the DAC consumes.

Parameters:
SIGNALWIDTH, 16, sample width of input and output words
FIFO_LOG2, 2, log2 of FIFO depth in stereo frames (default 4 frames)
RATE_LOG2, 10, log2 of clk cycles per output sample period (ramp length)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
in_valid  in  1  source frame valid
in_ready  out  1  FIFO can accept a frame this cycle
in_l  in  SIGNALWIDTH  left sample, two's complement
in_r  in  SIGNALWIDTH  right sample, two's complement
mute  in  1  force ramp target to signed zero (midscale)
d_l  out  SIGNALWIDTH  left DAC word, unsigned offset-binary
d_r  out  SIGNALWIDTH  right DAC word, unsigned offset-binary
underrun  out  1  one-cycle pulse: period tick found FIFO empty
fifo_level  out  FIFO_LOG2+1  current FIFO occupancy

Behaviour:
- Reset (async): FIFO empty, fifo_level=0, in_ready=1, phase counter=0, accumulators=0, step=0, underrun=0. d_l and d_r = midscale, 1 followed by SIGNALWIDTH-1 zeros (0x8000).
- in_ready = !full, derived from registered level. A push occurs when in_valid && in_ready. A pop in the same cycle never re-enables ready in that cycle.
- Phase counter: RATE_LOG2 bits, free-running, wraps from 2^RATE_LOG2-1 to 0. Tick = phase at its maximum value.
- On tick, if FIFO is non-empty: pop one frame as new targets.
- On tick, if FIFO is empty: targets = previous targets, and underrun pulses high for exactly one cycle.
- On tick, if mute=1: targets = 0 regardless. A frame is still popped if one is present; muted frames are discarded and not deferred.
- Simultaneous push and tick when empty: this counts as an underrun. The pushed frame is stored and becomes available at the next tick.
- Simultaneous push and pop when neither empty nor full: level unchanged.
- Per channel, the accumulator is signed, SIGNALWIDTH+RATE_LOG2+1 bits wide, with RATE_LOG2 fractional bits.
- Per channel, step is signed, SIGNALWIDTH+1 bits. On tick, step = new_target - old_target, computed at full width with no overflow.
- Every cycle after the tick, acc += sign-extended step. After exactly 2^RATE_LOG2 additions, acc equals new_target<<RATE_LOG2 exactly. There is no drift and no divider or multiplier.
- Output = acc integer part (floor, fraction truncated) with MSB inverted, registered. The output reflects the acc value of the previous cycle.
- Latency: a frame popped at tick T starts moving d at cycle T+2. It reaches its exact value at T+1+2^RATE_LOG2, which coincides with the next tick.
- Full-scale swing from -2^(SIGNALWIDTH-1) to 2^(SIGNALWIDTH-1)-1 is legal. The integer part never exceeds target bounds because the ramp is monotonic.
- fifo_level is registered and updates the cycle after push/pop.
- Reset mid-ramp returns outputs to midscale immediately and discards all FIFO contents.

Decomposition:
- Package audio_feeder_pkg:
  - SIGNALWIDTH default
  - function for midscale constant
  - function for signed-to-offset conversion (MSB invert)
  - acc/step width localparams derived from SIGNALWIDTH and RATE_LOG2
- Sub-module audio_sample_fifo:
  - synchronous FIFO, 2*SIGNALWIDTH wide, depth 2^FIFO_LOG2
  - valid/ready push, pop strobe, level, full, empty
  - async active-low reset
- Top instantiates one FIFO and two identical per-channel ramp datapaths; a generate loop is acceptable.

Test Plan (RATE_LOG2=4, FIFO_LOG2=2 unless noted):
- Reset release, no input -> d_l=d_r=0x8000 forever; underrun pulses every 16 cycles; in_ready=1; fifo_level=0.
- Push L=0x4000, R=0xC000 (signed) -> after next tick, d_l ramps 0x8000→0xC000 in 16 equal steps of 0x0400. d_r ramps 0x8000→0x4000 in the same way. Both are exact at the following tick.
- Push 5 frames back-to-back with no tick -> in_ready drops after the 4th push; the 5th is held by the source; fifo_level=4; no data lost; pops deliver frames in order.
- Full swing: 0x8000 then 0x7FFF signed -> d goes 0x0000→0xFFFF monotonically over 16 cycles; no wrap glitch at any cycle.
- mute=1 with FIFO holding 0x7FFF -> frame popped and discarded; d ramps to 0x8000 and holds while muted; first tick after mute=0 resumes with the next FIFO frame.
- Assert reset_n low mid-ramp with 3 frames queued -> outputs 0x8000 asynchronously; fifo_level=0 and in_ready=1 after release; next tick raises underrun.
